// File: rtl/lut_logic_pkg.sv
// Shared sizing helpers and parameter range limits for the programmable logic bank.
package lut_logic_pkg;

  localparam int unsigned NUM_IN_MIN  = 1;
  localparam int unsigned NUM_IN_MAX  = 6;
  localparam int unsigned NUM_OUT_MIN = 1;
  localparam int unsigned NUM_OUT_MAX = 16;
  localparam int unsigned PIPE_MIN    = 1;
  localparam int unsigned PIPE_MAX    = 4;

  function automatic int unsigned tt_width(input int unsigned num_in);
    return 1 << num_in;
  endfunction

  function automatic int unsigned sel_width(input int unsigned num_out);
    return (num_out > 1) ? $clog2(num_out) : 1;
  endfunction

endpackage

// File: rtl/lut_logic_cell.sv
// One programmable function: truth-table register, sticky-mode bit and the tt[x] lookup.
module lut_logic_cell
  import lut_logic_pkg::*;
#(
  parameter int unsigned NUM_IN = 3,
  parameter logic [tt_width(NUM_IN)-1:0] INIT = '0,
  localparam int unsigned TT_W = tt_width(NUM_IN)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              we,
  input  logic [TT_W-1:0]   tt_in,
  input  logic              sticky_in,
  input  logic [NUM_IN-1:0] x,
  output logic              z,
  output logic              sticky
);

  logic [TT_W-1:0] tt;

  always_ff @(posedge clk) begin
    if (reset) begin
      tt     <= INIT;
      sticky <= 1'b0;
    end else if (we) begin
      tt     <= tt_in;
      sticky <= sticky_in;
    end
  end

  assign z = tt[x];

endmodule

// File: rtl/lut_logic_bank.sv
// Programmable registered logic bank: NUM_OUT truth-table functions of x with a
// PIPE-deep valid pipeline and optional per-output sticky (latch-high) outputs.
module lut_logic_bank
  import lut_logic_pkg::*;
#(
  parameter int unsigned NUM_IN  = 3,
  parameter int unsigned NUM_OUT = 3,
  parameter int unsigned PIPE    = 1,
  parameter              INIT_TT = 24'h08BF8F,
  localparam int unsigned TT_W   = tt_width(NUM_IN),
  localparam int unsigned SEL_W  = sel_width(NUM_OUT)
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [NUM_IN-1:0]  x,
  input  logic               in_valid,
  input  logic               cfg_we,
  input  logic [SEL_W-1:0]   cfg_sel,
  input  logic [TT_W-1:0]    cfg_tt,
  input  logic               cfg_sticky,
  input  logic [NUM_OUT-1:0] sticky_clr,
  output logic [NUM_OUT-1:0] y,
  output logic               y_valid,
  output logic [NUM_OUT-1:0] z_comb,
  output logic               cfg_err
);

  if (NUM_IN < NUM_IN_MIN || NUM_IN > NUM_IN_MAX ||
      NUM_OUT < NUM_OUT_MIN || NUM_OUT > NUM_OUT_MAX ||
      PIPE < PIPE_MIN || PIPE > PIPE_MAX ||
      $bits(INIT_TT) != NUM_OUT * TT_W) begin : g_param_check
    $error("lut_logic_bank: parameter out of range or INIT_TT width mismatch");
  end

  logic [NUM_OUT-1:0] wr_en;
  logic [NUM_OUT-1:0] sticky_mode;
  logic               sel_bad;

  // Extra bit so NUM_OUT itself is representable when it is a power of two.
  assign sel_bad = ({1'b0, cfg_sel} >= (SEL_W + 1)'(NUM_OUT));

  for (genvar i = 0; i < NUM_OUT; i++) begin : g_cell
    assign wr_en[i] = cfg_we && (cfg_sel == SEL_W'(i));

    lut_logic_cell #(
      .NUM_IN (NUM_IN),
      .INIT   (INIT_TT[i*TT_W +: TT_W])
    ) u_cell (
      .clk       (clk),
      .reset     (reset),
      .we        (wr_en[i]),
      .tt_in     (cfg_tt),
      .sticky_in (cfg_sticky),
      .x         (x),
      .z         (z_comb[i]),
      .sticky    (sticky_mode[i])
    );
  end

  logic [NUM_OUT-1:0] fin_r;
  logic               fin_v;

  // With PIPE=1 the output register is the evaluation stage itself.
  if (PIPE > 1) begin : g_pipe
    logic [NUM_OUT-1:0] r_q [PIPE-1];
    logic               v_q [PIPE-1];

    for (genvar k = 0; k < PIPE - 1; k++) begin : g_stage
      if (k == 0) begin : g_first
        always_ff @(posedge clk) begin
          if (reset) begin
            v_q[0] <= 1'b0;
            r_q[0] <= '0;
          end else begin
            v_q[0] <= in_valid;
            r_q[0] <= z_comb;
          end
        end
      end else begin : g_next
        always_ff @(posedge clk) begin
          if (reset) begin
            v_q[k] <= 1'b0;
            r_q[k] <= '0;
          end else begin
            v_q[k] <= v_q[k-1];
            r_q[k] <= r_q[k-1];
          end
        end
      end
    end

    assign fin_r = r_q[PIPE-2];
    assign fin_v = v_q[PIPE-2];
  end else begin : g_direct
    assign fin_r = z_comb;
    assign fin_v = in_valid;
  end

  // A sticky set in the same cycle as a clear wins, so no event is lost.
  for (genvar i = 0; i < NUM_OUT; i++) begin : g_out
    always_ff @(posedge clk) begin
      if (reset) begin
        y[i] <= 1'b0;
      end else if (sticky_mode[i]) begin
        y[i] <= (fin_v & fin_r[i]) | (y[i] & ~sticky_clr[i]);
      end else if (fin_v) begin
        y[i] <= fin_r[i];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      y_valid <= 1'b0;
      cfg_err <= 1'b0;
    end else begin
      y_valid <= fin_v;
      cfg_err <= cfg_we && sel_bad;
    end
  end

endmodule

// File: tb/tb_lut_logic_bank.sv
// Directed self-checking bench for lut_logic_bank (default instance plus a PIPE=3 instance).
module tb_lut_logic_bank;

  logic       clk;
  logic       reset;
  logic [2:0] x;
  logic       in_valid;
  logic       cfg_we;
  logic [1:0] cfg_sel;
  logic [7:0] cfg_tt;
  logic       cfg_sticky;
  logic [2:0] sticky_clr;
  logic [2:0] y, z_comb, y3, z_comb3;
  logic       y_valid, cfg_err, y_valid3, cfg_err3;

  int errors = 0;
  int checks = 0;

  lut_logic_bank #(
    .NUM_IN  (3),
    .NUM_OUT (3),
    .PIPE    (1),
    .INIT_TT (24'h08BF8F)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .x          (x),
    .in_valid   (in_valid),
    .cfg_we     (cfg_we),
    .cfg_sel    (cfg_sel),
    .cfg_tt     (cfg_tt),
    .cfg_sticky (cfg_sticky),
    .sticky_clr (sticky_clr),
    .y          (y),
    .y_valid    (y_valid),
    .z_comb     (z_comb),
    .cfg_err    (cfg_err)
  );

  lut_logic_bank #(
    .PIPE (3)
  ) dut3 (
    .clk        (clk),
    .reset      (reset),
    .x          (x),
    .in_valid   (in_valid),
    .cfg_we     (cfg_we),
    .cfg_sel    (cfg_sel),
    .cfg_tt     (cfg_tt),
    .cfg_sticky (cfg_sticky),
    .sticky_clr (sticky_clr),
    .y          (y3),
    .y_valid    (y_valid3),
    .z_comb     (z_comb3),
    .cfg_err    (cfg_err3)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    in_valid   = 1'b0;
    cfg_we     = 1'b0;
    cfg_sticky = 1'b0;
    sticky_clr = '0;
  endtask

  task automatic test_reset();
    idle();
    reset = 1'b1; x = 3'b011; in_valid = 1'b1;
    step();
    checks++;
    if (y !== 3'b000) begin errors++; $display("FAIL reset_y: got %b expected %b", y, 3'b000); end
    checks++;
    if (y_valid !== 1'b0) begin errors++; $display("FAIL reset_y_valid: got %b expected 0", y_valid); end
    checks++;
    if (cfg_err !== 1'b0) begin errors++; $display("FAIL reset_cfg_err: got %b expected 0", cfg_err); end
    reset = 1'b0; in_valid = 1'b0;
    step();
    checks++;
    if (y_valid !== 1'b0 || y !== 3'b000) begin
      errors++; $display("FAIL reset_drop: got y=%b v=%b expected y=000 v=0", y, y_valid);
    end
  endtask

  task automatic test_basic();
    idle();
    x = 3'b011; in_valid = 1'b1; #1;
    checks++;
    if (z_comb !== 3'b111) begin errors++; $display("FAIL basic_z3: got %b expected 111", z_comb); end
    step();
    checks++;
    if (y !== 3'b111 || y_valid !== 1'b1) begin
      errors++; $display("FAIL basic_y3: got y=%b v=%b expected y=111 v=1", y, y_valid);
    end
    x = 3'b110; #1;
    checks++;
    if (z_comb !== 3'b000) begin errors++; $display("FAIL basic_z6: got %b expected 000", z_comb); end
    step();
    checks++;
    if (y !== 3'b000 || y_valid !== 1'b1) begin
      errors++; $display("FAIL basic_y6: got y=%b v=%b expected y=000 v=1", y, y_valid);
    end
    in_valid = 1'b0;
    step();
    checks++;
    if (y_valid !== 1'b0) begin errors++; $display("FAIL basic_v_drop: got %b expected 0", y_valid); end
  endtask

  task automatic test_cfg_same_cycle();
    idle();
    cfg_we = 1'b1; cfg_sel = 2'd2; cfg_tt = 8'hFF;
    x = 3'b000; in_valid = 1'b1;
    step();
    checks++;
    if (y !== 3'b011) begin errors++; $display("FAIL cfg_old_table: got %b expected 011", y); end
    checks++;
    if (cfg_err !== 1'b0) begin errors++; $display("FAIL cfg_err_valid_sel: got %b expected 0", cfg_err); end
    cfg_we = 1'b0; #1;
    checks++;
    if (z_comb !== 3'b111) begin errors++; $display("FAIL cfg_new_z: got %b expected 111", z_comb); end
    step();
    checks++;
    if (y !== 3'b111) begin errors++; $display("FAIL cfg_new_table: got %b expected 111", y); end
    in_valid = 1'b0; cfg_we = 1'b1; cfg_sel = 2'd2; cfg_tt = 8'h08;
    step();
    idle();
  endtask

  task automatic test_sticky();
    idle();
    cfg_we = 1'b1; cfg_sel = 2'd0; cfg_tt = 8'h8F; cfg_sticky = 1'b1;
    step();
    idle();
    x = 3'b011; in_valid = 1'b1;
    step();
    checks++;
    if (y !== 3'b111) begin errors++; $display("FAIL sticky_set: got %b expected 111", y); end
    x = 3'b110;
    step();
    checks++;
    if (y !== 3'b001) begin errors++; $display("FAIL sticky_hold: got %b expected 001", y); end
    in_valid = 1'b0; sticky_clr = 3'b001;
    step();
    checks++;
    if (y !== 3'b000 || y_valid !== 1'b0) begin
      errors++; $display("FAIL sticky_clr: got y=%b v=%b expected y=000 v=0", y, y_valid);
    end
    x = 3'b011; in_valid = 1'b1; sticky_clr = 3'b001;
    step();
    checks++;
    if (y !== 3'b111) begin errors++; $display("FAIL sticky_set_wins: got %b expected 111", y); end
    in_valid = 1'b0; sticky_clr = 3'b110;
    step();
    checks++;
    if (y !== 3'b111) begin errors++; $display("FAIL normal_clr_ignored: got %b expected 111", y); end
    sticky_clr = '0; cfg_we = 1'b1; cfg_sel = 2'd0; cfg_tt = 8'h8F; cfg_sticky = 1'b0;
    step();
    checks++;
    if (y !== 3'b111) begin errors++; $display("FAIL to_normal_keeps_y: got %b expected 111", y); end
    idle();
    x = 3'b110; in_valid = 1'b1;
    step();
    checks++;
    if (y !== 3'b000) begin errors++; $display("FAIL to_normal_follows: got %b expected 000", y); end
    idle();
  endtask

  task automatic test_cfg_err();
    idle();
    cfg_we = 1'b1; cfg_sel = 2'd3; cfg_tt = 8'h00; cfg_sticky = 1'b1;
    step();
    checks++;
    if (cfg_err !== 1'b1) begin errors++; $display("FAIL cfg_err_pulse: got %b expected 1", cfg_err); end
    idle();
    step();
    checks++;
    if (cfg_err !== 1'b0) begin errors++; $display("FAIL cfg_err_one_cycle: got %b expected 0", cfg_err); end
    test_basic();
  endtask

  task automatic test_idle();
    logic [2:0] xs [5];
    logic [2:0] zs [5];
    xs = '{3'd0, 3'd6, 3'd3, 3'd5, 3'd1};
    zs = '{3'b011, 3'b000, 3'b111, 3'b010, 3'b011};
    idle();
    x = 3'b011; in_valid = 1'b1;
    step();
    checks++;
    if (y !== 3'b111) begin errors++; $display("FAIL idle_prime: got %b expected 111", y); end
    in_valid = 1'b0;
    for (int i = 0; i < 5; i++) begin
      x = xs[i]; #1;
      checks++;
      if (z_comb !== zs[i]) begin
        errors++; $display("FAIL idle_z[%0d]: got %b expected %b", i, z_comb, zs[i]);
      end
      step();
      checks++;
      if (y !== 3'b111 || y_valid !== 1'b0) begin
        errors++; $display("FAIL idle_hold[%0d]: got y=%b v=%b expected y=111 v=0", i, y, y_valid);
      end
    end
  endtask

  task automatic test_back_to_back();
    logic [2:0] xs [4];
    logic [2:0] ys [4];
    xs = '{3'd3, 3'd6, 3'd0, 3'd3};
    ys = '{3'b111, 3'b000, 3'b011, 3'b111};
    idle();
    reset = 1'b1;
    step();
    reset = 1'b0;
    for (int s = 1; s <= 7; s++) begin
      logic       ev;
      logic [2:0] ey;
      in_valid = (s <= 4);
      x = (s <= 4) ? xs[s-1] : 3'd0;
      step();
      ev = (s >= 3 && s <= 6);
      ey = (s < 3) ? 3'b000 : (s > 6) ? 3'b111 : ys[s-3];
      checks++;
      if (y_valid3 !== ev) begin
        errors++; $display("FAIL b2b_valid[%0d]: got %b expected %b", s, y_valid3, ev);
      end
      checks++;
      if (y3 !== ey) begin
        errors++; $display("FAIL b2b_y[%0d]: got %b expected %b", s, y3, ey);
      end
    end
    x = 3'd3; in_valid = 1'b1;
    step();
    x = 3'd0;
    step();
    in_valid = 1'b0; reset = 1'b1;
    step();
    checks++;
    if (y3 !== 3'b000 || y_valid3 !== 1'b0) begin
      errors++; $display("FAIL midflight_reset: got y=%b v=%b expected y=000 v=0", y3, y_valid3);
    end
    reset = 1'b0;
    for (int s = 0; s < 4; s++) begin
      step();
      checks++;
      if (y3 !== 3'b000 || y_valid3 !== 1'b0) begin
        errors++; $display("FAIL no_stale[%0d]: got y=%b v=%b expected y=000 v=0", s, y3, y_valid3);
      end
    end
  endtask

  initial begin
    reset = 1'b1; x = '0; cfg_sel = '0; cfg_tt = '0;
    idle();
    step();
    test_reset();
    test_basic();
    test_cfg_same_cycle();
    test_sticky();
    test_cfg_err();
    test_idle();
    test_back_to_back();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
